// File: rtl/tx_if.sv
// tx_if: host-side bus of the UART transmitter.
// master: host/register side (drives data, strobes and config; reads line and status).
// slave : tx_block side.
// Signals: tx_data[8], data_write, error_clear, data_size[4], bit_period[14],
//          serial_out, buffer_full, tx_busy, tx_done, overrun_error.
interface tx_if;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned SIZE_W = 4;
    localparam int unsigned PER_W  = 14;

    logic [DATA_W-1:0] tx_data;
    logic              data_write;
    logic              error_clear;
    logic [SIZE_W-1:0] data_size;
    logic [PER_W-1:0]  bit_period;
    logic              serial_out;
    logic              buffer_full;
    logic              tx_busy;
    logic              tx_done;
    logic              overrun_error;

    modport master (
        output tx_data, data_write, error_clear, data_size, bit_period,
        input  serial_out, buffer_full, tx_busy, tx_done, overrun_error
    );

    modport slave (
        input  tx_data, data_write, error_clear, data_size, bit_period,
        output serial_out, buffer_full, tx_busy, tx_done, overrun_error
    );
endinterface

// File: rtl/tx_block.sv
// tx_block: UART-style serial transmitter with a single-entry holding buffer.
// Frame: start (0), 5..8 data bits LSB-first, optional even parity, one stop (1).
// Ports:
//   clk  - system clock, rising edge
//   rst  - asynchronous reset, active-high
//   bus  - tx_if.slave: tx_data, data_write, error_clear, data_size, bit_period in;
//          serial_out, buffer_full, tx_busy, tx_done, overrun_error out (all registered)
// Build option: define TX_PARITY_EN to insert an even-parity bit after the data bits.
module tx_block (
    input  logic clk,
    input  logic rst,
    tx_if.slave  bus
);
    localparam int unsigned DATA_W = 8;
    localparam int unsigned SIZE_W = 4;
    localparam int unsigned PER_W  = 14;
    localparam int unsigned IDX_W  = 3;

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
`ifdef TX_PARITY_EN
    localparam logic [2:0] PARITY = 3'd3;
`endif
    localparam logic [2:0] STOP   = 3'd4;

    logic [2:0]        state_q, state_d;
    logic [PER_W-1:0]  cnt_q, cnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [DATA_W-1:0] hold_q, hold_d;
    logic [SIZE_W-1:0] size_q, size_d;
    logic [PER_W-1:0]  per_q, per_d;
    logic              full_q, full_d;
    logic              serial_q, serial_d;
    logic              done_q, done_d;
    logic              busy_q, busy_d;
    logic              ovr_q, ovr_d;
`ifdef TX_PARITY_EN
    logic              par_q, par_d;
`endif

    logic [SIZE_W-1:0] size_c;
    logic [PER_W-1:0]  per_c;
    logic              last_c;
    logic              final_bit_c;
    logic              load_c;

    // Configuration clamps applied when a frame is loaded
    assign size_c = (bus.data_size < SIZE_W'(5)) ? SIZE_W'(5) :
                    (bus.data_size > SIZE_W'(8)) ? SIZE_W'(8) : bus.data_size;
    assign per_c  = (bus.bit_period < PER_W'(2)) ? PER_W'(2) : bus.bit_period;

    assign last_c      = (cnt_q == per_q - PER_W'(1));
    assign final_bit_c = (SIZE_W'(idx_q) == size_q - SIZE_W'(1));
    // Load from the buffer when idle, or at the end of a stop bit for back-to-back frames
    assign load_c      = full_q && ((state_q == IDLE) || ((state_q == STOP) && last_c));

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            shift_q  <= '0;
            hold_q   <= '0;
            size_q   <= '0;
            per_q    <= '0;
            full_q   <= 1'b0;
            serial_q <= 1'b1;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
            ovr_q    <= 1'b0;
`ifdef TX_PARITY_EN
            par_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            shift_q  <= shift_d;
            hold_q   <= hold_d;
            size_q   <= size_d;
            per_q    <= per_d;
            full_q   <= full_d;
            serial_q <= serial_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
            ovr_q    <= ovr_d;
`ifdef TX_PARITY_EN
            par_q    <= par_d;
`endif
        end
    end

    // Next-state, next line bit and buffer bookkeeping
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        shift_d  = shift_q;
        hold_d   = hold_q;
        size_d   = size_q;
        per_d    = per_q;
        full_d   = full_q;
        serial_d = serial_q;
        done_d   = 1'b0;
        ovr_d    = ovr_q;
`ifdef TX_PARITY_EN
        par_d    = par_q;
`endif

        case (state_q)
            IDLE: begin
                serial_d = 1'b1;
            end
            START: begin
                if (last_c) begin
                    state_d  = DATA;
                    cnt_d    = '0;
                    idx_d    = '0;
                    serial_d = shift_q[0];
`ifdef TX_PARITY_EN
                    par_d    = par_q ^ shift_q[0];
`endif
                end else begin
                    cnt_d = cnt_q + PER_W'(1);
                end
            end
            DATA: begin
                if (last_c) begin
                    cnt_d = '0;
                    if (final_bit_c) begin
`ifdef TX_PARITY_EN
                        state_d  = PARITY;
                        serial_d = par_q;
`else
                        state_d  = STOP;
                        serial_d = 1'b1;
`endif
                    end else begin
                        // shift_q[0] is on the line; bring up the next bit
                        idx_d    = idx_q + IDX_W'(1);
                        shift_d  = shift_q >> 1;
                        serial_d = shift_q[1];
`ifdef TX_PARITY_EN
                        par_d    = par_q ^ shift_q[1];
`endif
                    end
                end else begin
                    cnt_d = cnt_q + PER_W'(1);
                end
            end
`ifdef TX_PARITY_EN
            PARITY: begin
                if (last_c) begin
                    state_d  = STOP;
                    cnt_d    = '0;
                    serial_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + PER_W'(1);
                end
            end
`endif
            STOP: begin
                if (last_c) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + PER_W'(1);
                end
            end
            default: begin
                state_d  = IDLE;
                cnt_d    = '0;
                serial_d = 1'b1;
            end
        endcase

        // Frame load overrides the STOP->IDLE decision
        if (load_c) begin
            state_d  = START;
            cnt_d    = '0;
            shift_d  = hold_q;
            size_d   = size_c;
            per_d    = per_c;
            serial_d = 1'b0;
            full_d   = 1'b0;
`ifdef TX_PARITY_EN
            par_d    = 1'b0;
`endif
        end

        // A new overrun in the same cycle as error_clear keeps the flag set
        if (bus.error_clear) begin
            ovr_d = 1'b0;
        end
        if (bus.data_write) begin
            if (!full_q || load_c) begin
                hold_d = bus.tx_data;
                full_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end
    end

    assign busy_d = (state_d != IDLE);

    assign bus.serial_out    = serial_q;
    assign bus.buffer_full   = full_q;
    assign bus.tx_busy       = busy_q;
    assign bus.tx_done       = done_q;
    assign bus.overrun_error = ovr_q;
endmodule
